// File: rtl/timer_counter.sv
// Prescaled up/down/centre-aligned timer with one-shot and shadowed period/prescale.
// Feeds count_val, dir and ovf/udf event pulses to the compare/PWM stages.
module timer_counter #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             count_reset,
  input  logic [1:0]       mode,
  input  logic             one_shot,
  input  logic             preload_en,
  input  logic [WIDTH-1:0] period,
  input  logic [PSC_W-1:0] prescale,
  output logic [WIDTH-1:0] count_val,
  output logic             dir,
  output logic             ovf,
  output logic             udf,
  output logic             done
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] P_ONE  = {{(PSC_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_sh_q, per_sh_d;
  logic [PSC_W-1:0] psc_sh_q, psc_sh_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             dir_r_q, dir_r_d;
  logic             dir_q, dir_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] p_act;
  logic [PSC_W-1:0] s_act;
  logic             run, tick, upd;
  logic             is_down, is_updn;

  assign is_down = (mode == 2'b01);
  assign is_updn = (mode == 2'b10);

  always_comb begin
    p_act    = preload_en ? per_sh_q : period;
    s_act    = preload_en ? psc_sh_q : prescale;
    run      = en & ~done_q;
    tick     = run & (psc_q >= s_act);
    upd      = 1'b0;
    cnt_d    = cnt_q;
    per_sh_d = per_sh_q;
    psc_sh_d = psc_sh_q;
    psc_d    = psc_q;
    dir_r_d  = dir_r_q;
    dir_d    = dir_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    done_d   = done_q;
    if (count_reset) begin
      psc_d    = '0;
      dir_r_d  = 1'b1;
      done_d   = 1'b0;
      per_sh_d = period;
      psc_sh_d = prescale;
      cnt_d    = is_down ? period : C_ZERO;
      dir_d    = ~is_down;
    end else if (run) begin
      psc_d = tick ? '0 : psc_q + P_ONE;
      if (tick) begin
        unique case (1'b1)
          is_down: begin
            if (cnt_q == C_ZERO) begin
              cnt_d = p_act;
              udf_d = 1'b1;
              upd   = 1'b1;
            end else begin
              cnt_d = cnt_q - C_ONE;
            end
          end
          is_updn: begin
            if (dir_r_q) begin
              if (cnt_q >= p_act) begin
                cnt_d   = (p_act == C_ZERO) ? C_ZERO : p_act - C_ONE;
                dir_r_d = 1'b0;
                ovf_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + C_ONE;
              end
            end else if (cnt_q == C_ZERO) begin
              cnt_d   = (p_act == C_ZERO) ? C_ZERO : C_ONE;
              dir_r_d = 1'b1;
              udf_d   = 1'b1;
              upd     = 1'b1;
            end else begin
              cnt_d = cnt_q - C_ONE;
            end
          end
          default: begin
            if (cnt_q >= p_act) begin
              cnt_d = C_ZERO;
              ovf_d = 1'b1;
              upd   = 1'b1;
            end else begin
              cnt_d = cnt_q + C_ONE;
            end
          end
        endcase
        dir_d = is_down ? 1'b0 : (is_updn ? dir_r_d : 1'b1);
        // new shadow values apply from the next tick onwards
        if (upd) begin
          per_sh_d = period;
          psc_sh_d = prescale;
          done_d   = done_q | one_shot;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      per_sh_q <= period;
      psc_sh_q <= prescale;
      psc_q    <= '0;
      dir_r_q  <= 1'b1;
      dir_q    <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      per_sh_q <= per_sh_d;
      psc_sh_q <= psc_sh_d;
      psc_q    <= psc_d;
      dir_r_q  <= dir_r_d;
      dir_q    <= dir_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      done_q   <= done_d;
    end
  end

  assign count_val = cnt_q;
  assign dir       = dir_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign done      = done_q;

endmodule
